// File: rtl/secded_pkg.sv
// Shared constants, scrub FSM encodings and read classification for the
// SECDED scrub controller.
package secded_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORD_W = 39;
  localparam int unsigned SYND_W = WORD_W - DATA_W;

  typedef logic [2:0] scrub_state_t;

  localparam scrub_state_t ST_IDLE = 3'd0;
  localparam scrub_state_t ST_WAIT = 3'd1;
  localparam scrub_state_t ST_RD   = 3'd2;
  localparam scrub_state_t ST_CHK  = 3'd3;
  localparam scrub_state_t ST_WB   = 3'd4;

  typedef enum logic [1:0] {CLEAN, CE, UE} cls_e;

endpackage

// File: rtl/secded_syndrome.sv
// Combinational SECDED syndrome, single-bit correction and classification
// of one 39-bit codeword.
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] corrected,
  output cls_e              cls
);

  logic [SYND_W-1:0] synd;
  logic [SYND_W-2:0] pos;

  // Hamming checks over positions 1..39 plus overall parity in the top bit.
  always_comb begin
    synd = '0;
    for (int j = 1; j <= int'(WORD_W); j++) begin
      for (int i = 0; i < int'(SYND_W) - 1; i++) begin
        if (((j >> i) & 1) == 1) synd[i] = synd[i] ^ word[j-1];
      end
    end
    synd[SYND_W-1] = ^word;
  end

  assign pos = synd[SYND_W-2:0];

  always_comb begin
    corrected = word;
    cls       = CLEAN;
    if (synd != '0) begin
      if (!synd[SYND_W-1]) begin
        cls = UE;
      end else if (pos == '0) begin
        cls = CE;
      end else if (pos <= (SYND_W-1)'(WORD_W)) begin
        cls       = CE;
        corrected = word ^ (WORD_W'(1) << (pos - (SYND_W-1)'(1)));
      end else begin
        cls = UE;
      end
    end
  end

endmodule

// File: rtl/secded_scrub_ctrl.sv
// Memory-port arbiter between CPU and background SECDED scrubber.
// Define SECDED_SCRUB_WB_EN to enable write-back of corrected words.
module secded_scrub_ctrl
  import secded_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned SCRUB_INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ce,
  output logic              cpu_ue,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              scrub_en,
  input  logic              clr_stats,
  output logic [15:0]       ce_count,
  output logic [15:0]       ue_count,
  output logic              ue_flag,
  output logic [ADDR_W-1:0] ue_addr,
  output logic              scrub_wrap
);

  localparam int unsigned       CNT_W     = $clog2(SCRUB_INTERVAL) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_t      state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] scrub_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] corrected;
  cls_e              cls;
  logic              scrub_issue;
  logic              scrub_adv;
  logic              rd_ret;
  logic              need_wb;

  secded_syndrome u_syndrome (
    .word      (mem_rdata),
    .corrected (corrected),
    .cls       (cls)
  );

  assign cpu_rdata   = corrected;
  assign cpu_ce      = cpu_rvalid && (cls == CE);
  assign cpu_ue      = cpu_rvalid && (cls == UE);
  assign scrub_issue = !rst && (state == ST_RD) && !cpu_req;
  assign rd_ret      = cpu_rvalid || (state == ST_CHK);

`ifdef SECDED_SCRUB_WB_EN
  logic              collide;
  logic              wb_issue;
  logic [WORD_W-1:0] wb_data;

  assign cpu_gnt   = cpu_req && (state != ST_WB);
  // A CPU write landing on the word under check makes the correction stale.
  assign collide   = cpu_gnt && cpu_we && (cpu_addr == scrub_addr);
  assign need_wb   = (state == ST_CHK) && (cls == CE) && (corrected != mem_rdata) && !collide;
  assign wb_issue  = !rst && (state == ST_WB);
  assign scrub_adv = ((state == ST_CHK) && !need_wb) || (state == ST_WB);
  assign mem_en    = !rst && (cpu_gnt || scrub_issue || wb_issue);
  assign mem_we    = !rst && (cpu_gnt ? cpu_we : wb_issue);
  assign mem_wdata = wb_issue ? wb_data : cpu_wdata;

  always_ff @(posedge clk) begin
    if (need_wb) wb_data <= corrected;
  end
`else
  assign cpu_gnt   = cpu_req;
  assign need_wb   = 1'b0;
  assign scrub_adv = (state == ST_CHK);
  assign mem_en    = !rst && (cpu_gnt || scrub_issue);
  assign mem_we    = !rst && cpu_gnt && cpu_we;
  assign mem_wdata = cpu_wdata;
`endif

  assign mem_addr = cpu_gnt ? cpu_addr : scrub_addr;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (scrub_en) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!scrub_en)           state_nxt = ST_IDLE;
        else if (wait_cnt == '0) state_nxt = ST_RD;
      end
      ST_RD:   if (!cpu_req) state_nxt = ST_CHK;
      ST_CHK: begin
        if (need_wb)       state_nxt = ST_WB;
        else if (scrub_en) state_nxt = ST_WAIT;
        else               state_nxt = ST_IDLE;
      end
`ifdef SECDED_SCRUB_WB_EN
      ST_WB:   state_nxt = scrub_en ? ST_WAIT : ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      scrub_addr <= '0;
      scrub_wrap <= 1'b0;
      cpu_rvalid <= 1'b0;
      rd_addr    <= '0;
      ce_count   <= '0;
      ue_count   <= '0;
      ue_flag    <= 1'b0;
      ue_addr    <= '0;
    end else begin
      state      <= state_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      if (cpu_gnt && !cpu_we) rd_addr <= cpu_addr;

      if ((state_nxt == ST_WAIT) && (state != ST_WAIT))  wait_cnt <= CNT_LOAD;
      else if ((state == ST_WAIT) && (wait_cnt != '0))    wait_cnt <= wait_cnt - CNT_W'(1);

      scrub_wrap <= scrub_adv && (scrub_addr == LAST_ADDR);
      if (scrub_adv) scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + ADDR_W'(1);

      // Clearing takes precedence over any same-cycle event.
      if (clr_stats) begin
        ce_count <= '0;
        ue_count <= '0;
        ue_flag  <= 1'b0;
        ue_addr  <= '0;
      end else begin
        if (rd_ret && (cls == CE) && (ce_count != '1)) ce_count <= ce_count + 16'd1;
        if (rd_ret && (cls == UE)) begin
          if (ue_count != '1) ue_count <= ue_count + 16'd1;
          if (!ue_flag) begin
            ue_flag <= 1'b1;
            ue_addr <= cpu_rvalid ? rd_addr : scrub_addr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Directed self-checking bench for secded_scrub_ctrl with a small behavioural
// memory; follows the SECDED_SCRUB_WB_EN build option of the design.
module tb_secded_scrub_ctrl;

  localparam int unsigned DEPTH          = 8;
  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned SCRUB_INTERVAL = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [38:0]       cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid, cpu_ce, cpu_ue;
  logic [38:0]       cpu_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [38:0]       mem_wdata;
  logic [38:0]       mem_rdata = '0;
  logic              scrub_en = 1'b0;
  logic              clr_stats = 1'b0;
  logic [15:0]       ce_count, ue_count;
  logic              ue_flag;
  logic [ADDR_W-1:0] ue_addr;
  logic              scrub_wrap;

  int total = 0;
  int bad   = 0;
  int scrub_wr = 0;
  logic [38:0] mem [DEPTH];
  logic [38:0] w [DEPTH];

  always #5 clk = ~clk;

  secded_scrub_ctrl #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_ce     (cpu_ce),
    .cpu_ue     (cpu_ue),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .scrub_en   (scrub_en),
    .clr_stats  (clr_stats),
    .ce_count   (ce_count),
    .ue_count   (ue_count),
    .ue_flag    (ue_flag),
    .ue_addr    (ue_addr),
    .scrub_wrap (scrub_wrap)
  );

  // Single-port memory with one-cycle read latency; counts non-CPU writes.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (mem_en && mem_we && !cpu_gnt) scrub_wr <= scrub_wr + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Builds a valid codeword: data in non-power-of-two positions 1..38,
  // position 39 chosen so the overall parity comes out even.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  s;
    int          k;
    cw = '0;
    for (int pbit = 0; pbit < 2; pbit++) begin
      cw = '0;
      k  = 0;
      for (int j = 1; j <= 38; j++) begin
        if ((j & (j - 1)) != 0) begin
          cw[j-1] = d[k];
          k++;
        end
      end
      cw[38] = (pbit == 1);
      s = '0;
      for (int j = 1; j <= 39; j++)
        for (int i = 0; i < 6; i++)
          if (((j >> i) & 1) == 1) s[i] = s[i] ^ cw[j-1];
      for (int i = 0; i < 6; i++) cw[(1 << i) - 1] = s[i];
      if ((^cw) == 1'b0) return cw;
    end
    return cw;
  endfunction

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [38:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    for (int i = 0; i < 8 && !cpu_gnt; i++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL write_gnt addr=%0d got=%b want=1", a, cpu_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic rv,
                          output logic [38:0] rd, output logic ce, output logic ue);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    rv = cpu_rvalid; rd = cpu_rdata; ce = cpu_ce; ue = cpu_ue;
    cpu_req = 1'b0;
  endtask

  task automatic wait_wrap(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (scrub_wrap === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: no scrub_wrap within 300 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = 39'h1; scrub_en = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_mem: got en=%b we=%b want 0 0", mem_en, mem_we);
    end
    cpu_req = 1'b0; cpu_we = 1'b0; scrub_en = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b0 || scrub_wrap !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulses: got rvalid=%b wrap=%b want 0 0", cpu_rvalid, scrub_wrap);
    end
    total++;
    if (ce_count !== 16'd0 || ue_count !== 16'd0 || ue_flag !== 1'b0 || ue_addr !== '0) begin
      bad++;
      $display("FAIL rst_stats: got ce=%0d ue=%0d flag=%b addr=%0d want 0 0 0 0",
               ce_count, ue_count, ue_flag, ue_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    logic rv, ce, ue;
    logic [38:0] rd;
    for (int a = 0; a < int'(DEPTH); a++) begin
      w[a] = enc({16'hC0DE, 13'h0, 3'(a)});
      case (a)
        3:       cpu_write(3'(a), w[a] ^ (39'd1 << 12));
        7:       cpu_write(3'(a), w[a] ^ (39'd1 << 2) ^ (39'd1 << 9));
        default: cpu_write(3'(a), w[a]);
      endcase
    end
    cpu_read(3'd5, rv, rd, ce, ue);
    total++;
    if (rv !== 1'b1 || rd !== w[5] || ce !== 1'b0 || ue !== 1'b0) begin
      bad++;
      $display("FAIL rd_clean: got rv=%b data=%h ce=%b ue=%b want 1 %h 0 0", rv, rd, ce, ue, w[5]);
    end
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd_rvalid_drop: got %b want 0", cpu_rvalid);
    end
    cpu_read(3'd3, rv, rd, ce, ue);
    total++;
    if (rv !== 1'b1 || rd !== w[3] || ce !== 1'b1 || ue !== 1'b0) begin
      bad++;
      $display("FAIL rd_ce: got rv=%b data=%h ce=%b ue=%b want 1 %h 1 0", rv, rd, ce, ue, w[3]);
    end
    cpu_read(3'd7, rv, rd, ce, ue);
    total++;
    if (rv !== 1'b1 || ce !== 1'b0 || ue !== 1'b1) begin
      bad++;
      $display("FAIL rd_ue: got rv=%b ce=%b ue=%b want 1 0 1", rv, ce, ue);
    end
    @(negedge clk);
    total++;
    if (ce_count !== 16'd1 || ue_count !== 16'd1 || ue_flag !== 1'b1 || ue_addr !== 3'd7) begin
      bad++;
      $display("FAIL rd_stats: got ce=%0d ue=%0d flag=%b addr=%0d want 1 1 1 7",
               ce_count, ue_count, ue_flag, ue_addr);
    end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    total++;
    if (ce_count !== 16'd0 || ue_count !== 16'd0 || ue_flag !== 1'b0 || ue_addr !== '0) begin
      bad++;
      $display("FAIL clr_stats: got ce=%0d ue=%0d flag=%b addr=%0d want 0 0 0 0",
               ce_count, ue_count, ue_flag, ue_addr);
    end
  endtask

  task automatic test_scrub_pass();
    int exp_wr;
    logic [38:0] exp3;
`ifdef SECDED_SCRUB_WB_EN
    exp_wr = 1;
    exp3   = w[3];
`else
    exp_wr = 0;
    exp3   = w[3] ^ (39'd1 << 12);
`endif
    scrub_en = 1'b1;
    wait_wrap("pass1_wrap");
    total++;
    if (ce_count !== 16'd1 || ue_count !== 16'd1 || ue_flag !== 1'b1 || ue_addr !== 3'd7) begin
      bad++;
      $display("FAIL pass1_stats: got ce=%0d ue=%0d flag=%b addr=%0d want 1 1 1 7",
               ce_count, ue_count, ue_flag, ue_addr);
    end
    total++;
    if (mem[3] !== exp3 || scrub_wr != exp_wr) begin
      bad++;
      $display("FAIL pass1_wb: got mem3=%h writes=%0d want %h %0d", mem[3], scrub_wr, exp3, exp_wr);
    end
    total++;
    if (mem[5] !== w[5] || mem[7] !== (w[7] ^ (39'd1 << 2) ^ (39'd1 << 9))) begin
      bad++;
      $display("FAIL pass1_untouched: got mem5=%h mem7=%h", mem[5], mem[7]);
    end
    @(negedge clk);
    total++;
    if (scrub_wrap !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pulse: got %b want 0", scrub_wrap);
    end
    cpu_write(3'd6, w[6] ^ 39'd3);
    wait_wrap("pass2_wrap");
    total++;
`ifdef SECDED_SCRUB_WB_EN
    if (ce_count !== 16'd1 || ue_count !== 16'd3 || ue_addr !== 3'd7) begin
      bad++;
      $display("FAIL pass2_stats: got ce=%0d ue=%0d addr=%0d want 1 3 7", ce_count, ue_count, ue_addr);
    end
`else
    if (ce_count !== 16'd2 || ue_count !== 16'd3 || ue_addr !== 3'd7) begin
      bad++;
      $display("FAIL pass2_stats: got ce=%0d ue=%0d addr=%0d want 2 3 7", ce_count, ue_count, ue_addr);
    end
`endif
    total++;
    if (scrub_wr != exp_wr) begin
      bad++;
      $display("FAIL pass2_writes: got %0d want %0d", scrub_wr, exp_wr);
    end
  endtask

  task automatic test_cpu_stall();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'd0) begin
        bad++;
        $display("FAIL stall_cyc%0d: got gnt=%b en=%b we=%b addr=%0d want 1 1 0 0",
                 i, cpu_gnt, mem_en, mem_we, mem_addr);
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    #1;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: got en=%b we=%b want 1 0", mem_en, mem_we);
    end
  endtask

`ifdef SECDED_SCRUB_WB_EN
  task automatic test_collision();
    logic [38:0] fresh;
    bit found;
    fresh = enc(32'h1234_5678);
    found = 1'b0;
    cpu_write(3'd4, w[4] ^ 39'd1);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_en && !mem_we && !cpu_req && mem_addr == 3'd4) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL coll_find: scrub read of addr 4 not seen");
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd4; cpu_wdata = fresh;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL coll_gnt: got %b want 1", cpu_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    total++;
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      bad++;
      $display("FAIL coll_no_wb: got en=%b we=%b want no write", mem_en, mem_we);
    end
    repeat (3) @(negedge clk);
    total++;
    if (mem[4] !== fresh || scrub_wr != 1 || ce_count !== 16'd2) begin
      bad++;
      $display("FAIL coll_result: got mem4=%h writes=%0d ce=%0d want %h 1 2",
               mem[4], scrub_wr, ce_count, fresh);
    end
  endtask
`endif

  task automatic test_saturation();
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    cpu_write(3'd2, w[2] ^ (39'd1 << 20));
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2;
    repeat (65540) @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ce_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL ce_saturate: got %h want ffff", ce_count);
    end
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    clr_stats = 1'b1;
    #1;
    total++;
    if (cpu_ce !== 1'b1) begin
      bad++;
      $display("FAIL clr_ce_return: got ce=%b want 1", cpu_ce);
    end
    @(negedge clk);
    clr_stats = 1'b0;
    total++;
    if (ce_count !== 16'd0) begin
      bad++;
      $display("FAIL clr_wins: got %0d want 0", ce_count);
    end
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (ce_count !== 16'd1) begin
      bad++;
      $display("FAIL ce_after_clr: got %0d want 1", ce_count);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_scrub_pass();
    test_cpu_stall();
`ifdef SECDED_SCRUB_WB_EN
    test_collision();
`endif
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
